// File: rtl/fb_port_arbiter.sv
// Framebuffer port arbiter: shares a single memory port between a display
// read port and a draw write port. Reads win by default; a waiting write is
// forced through after STARVE_MAX consecutive read grants. All outputs are
// registered.
//
// Handshake: a requester raises req with stable coordinates (and data) and
// holds them until it sees its one-cycle gnt pulse. Requests are only looked
// at while the FSM is in IDLE. A read then returns one rd_valid pulse with
// rd_data a fixed latency after its grant.
module fb_port_arbiter #(
   parameter int VGA_ADDR_WIDTH = 19,
   parameter int H_PHY_WIDTH    = 10,
   parameter int V_PHY_WIDTH    = 9,
   parameter int H_PHY_MAX      = 639,
   parameter int V_PHY_MAX      = 479,
   parameter int ADDR_OFFSET    = 2,
   parameter int DATA_WIDTH     = 16,
   parameter int MEM_LAT        = 2,
   parameter int STARVE_MAX     = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      rd_req,
   input  logic [H_PHY_WIDTH-1:0]    rd_x,
   input  logic [V_PHY_WIDTH-1:0]    rd_y,
   output logic                      rd_gnt,
   output logic                      rd_valid,
   output logic [DATA_WIDTH-1:0]     rd_data,
   input  logic                      wr_req,
   input  logic [H_PHY_WIDTH-1:0]    wr_x,
   input  logic [V_PHY_WIDTH-1:0]    wr_y,
   input  logic [DATA_WIDTH-1:0]     wr_data,
   output logic                      wr_gnt,
   output logic                      mem_en,
   output logic                      mem_we,
   output logic [VGA_ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]     mem_wdata,
   input  logic [DATA_WIDTH-1:0]     mem_rdata
);

   typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_WAIT, RD_DONE} state_t;

   localparam int WW = $clog2(STARVE_MAX + 1);
   localparam logic [WW-1:0]             STARVE_W = WW'(STARVE_MAX);
   localparam logic [2:0]                LAT_LAST = 3'(MEM_LAT - 1);
   localparam logic [H_PHY_WIDTH-1:0]    H_MAX    = H_PHY_WIDTH'(H_PHY_MAX);
   localparam logic [V_PHY_WIDTH-1:0]    V_MAX    = V_PHY_WIDTH'(V_PHY_MAX);
   localparam logic [VGA_ADDR_WIDTH-1:0] LINE     = VGA_ADDR_WIDTH'(H_PHY_MAX + 1);
   localparam logic [VGA_ADDR_WIDTH-1:0] OFFS     = VGA_ADDR_WIDTH'(ADDR_OFFSET);

   state_t                    state, next_state;
   logic [WW-1:0]             wr_wait;
   logic [2:0]                wait_cnt;
   logic                      rd_oor_q;
   logic                      grant_rd, grant_wr;
   logic                      rd_oor, wr_oor;
   logic [VGA_ADDR_WIDTH-1:0] rd_addr, wr_addr;

   // Address mapping, range checks and the IDLE arbitration decision.
   always_comb begin
      rd_oor   = (rd_x > H_MAX) || (rd_y > V_MAX);
      wr_oor   = (wr_x > H_MAX) || (wr_y > V_MAX);
      rd_addr  = VGA_ADDR_WIDTH'(rd_y) * LINE + VGA_ADDR_WIDTH'(rd_x) + OFFS;
      wr_addr  = VGA_ADDR_WIDTH'(wr_y) * LINE + VGA_ADDR_WIDTH'(wr_x) + OFFS;
      grant_rd = rd_req && (!wr_req || (wr_wait < STARVE_W));
      grant_wr = wr_req && !grant_rd;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // Next-state logic. RD_WAIT covers the MEM_LAT cycles between the strobe
   // and the cycle in which mem_rdata is valid; the capture happens on the
   // way out of RD_WAIT so rd_valid lands in RD_DONE.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (grant_rd)      next_state = RD_ISSUE;
            else if (grant_wr) next_state = WR;
         end
         WR:       next_state = IDLE;
         RD_ISSUE: next_state = RD_WAIT;
         RD_WAIT:  if (wait_cnt == 3'd0) next_state = RD_DONE;
         RD_DONE:  next_state = IDLE;
         default:  next_state = IDLE;
      endcase
   end

   // Read latency counter and write starvation counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= 3'd0;
         wr_wait  <= '0;
      end else begin
         if (state == RD_ISSUE)                          wait_cnt <= LAT_LAST;
         else if (state == RD_WAIT && wait_cnt != 3'd0) wait_cnt <= wait_cnt - 3'd1;
         if (state == IDLE) begin
            if (grant_wr || !wr_req)                 wr_wait <= '0;
            else if (grant_rd && wr_wait < STARVE_W) wr_wait <= wr_wait + WW'(1);
         end
      end
   end

   // Registered outputs: strobes are single-cycle pulses, buses hold their
   // last value. Out-of-range accesses are granted but never reach memory.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_gnt    <= 1'b0;
         wr_gnt    <= 1'b0;
         rd_valid  <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rd_data   <= '0;
         rd_oor_q  <= 1'b0;
      end else begin
         rd_gnt   <= 1'b0;
         wr_gnt   <= 1'b0;
         rd_valid <= 1'b0;
         mem_en   <= 1'b0;
         mem_we   <= 1'b0;
         if (state == IDLE && grant_rd) begin
            rd_gnt   <= 1'b1;
            mem_en   <= !rd_oor;
            rd_oor_q <= rd_oor;
            if (!rd_oor) mem_addr <= rd_addr;
         end else if (state == IDLE && grant_wr) begin
            wr_gnt <= 1'b1;
            mem_en <= !wr_oor;
            mem_we <= !wr_oor;
            if (!wr_oor) begin
               mem_addr  <= wr_addr;
               mem_wdata <= wr_data;
            end
         end
         if (state == RD_WAIT && wait_cnt == 3'd0) begin
            rd_valid <= 1'b1;
            rd_data  <= rd_oor_q ? '0 : mem_rdata;
         end
      end
   end

endmodule
